// File: rtl/ram1p_arb.sv
// rtl/ram1p_arb.sv - clear sweep plus round-robin arbiter in front of one single-port byte-write SRAM
module ram1p_arb #(
    parameter int DEPTH = 64,
    parameter int WIDTH = 44,
    localparam int AW = $clog2(DEPTH),
    localparam int BW = (WIDTH - 1) / 8 + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush_req,
    output logic             init_busy,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic             req0_we,
    input  logic [AW-1:0]    req0_addr,
    input  logic [BW-1:0]    req0_bwe,
    input  logic [WIDTH-1:0] req0_din,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic             req1_we,
    input  logic [AW-1:0]    req1_addr,
    input  logic [BW-1:0]    req1_bwe,
    input  logic [WIDTH-1:0] req1_din,
    output logic             rsp0_valid,
    output logic             rsp1_valid,
    output logic [WIDTH-1:0] rsp_data,
    output logic             ram_ce,
    output logic             ram_we,
    output logic [AW-1:0]    ram_addr,
    output logic [BW-1:0]    ram_bwe,
    output logic [WIDTH-1:0] ram_din,
    input  logic [WIDTH-1:0] ram_dout
);

    typedef enum logic {S_INIT, S_ARB} state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] cnt_q, cnt_d;
    logic          last_q, last_d;    // 1 = requester 1 was granted last, so 0 wins a tie
    logic          rsp0_q, rsp0_d;
    logic          rsp1_q, rsp1_d;
    logic          gnt0, gnt1;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        last_d   = last_q;
        rsp0_d   = 1'b0;
        rsp1_d   = 1'b0;
        gnt0     = 1'b0;
        gnt1     = 1'b0;
        ram_ce   = 1'b0;
        ram_we   = 1'b0;
        ram_addr = '0;
        ram_bwe  = '0;
        ram_din  = '0;
        if (state_q == S_INIT) begin
            ram_ce   = 1'b1;
            ram_we   = 1'b1;
            ram_bwe  = '1;
            ram_addr = cnt_q;
            if (cnt_q == AW'(DEPTH - 1)) begin
                cnt_d   = '0;
                state_d = S_ARB;
            end else begin
                cnt_d = cnt_q + AW'(1);
            end
        end else if (flush_req) begin
            // Flush wins over any pending request; the sweep starts next cycle.
            state_d = S_INIT;
            cnt_d   = '0;
        end else begin
            gnt0 = req0_valid & (~req1_valid | last_q);
            gnt1 = req1_valid & (~req0_valid | ~last_q);
            if (gnt0) begin
                ram_ce   = 1'b1;
                ram_we   = req0_we;
                ram_addr = req0_addr;
                ram_bwe  = req0_bwe;
                ram_din  = req0_din;
                last_d   = 1'b0;
                rsp0_d   = ~req0_we;
            end else if (gnt1) begin
                ram_ce   = 1'b1;
                ram_we   = req1_we;
                ram_addr = req1_addr;
                ram_bwe  = req1_bwe;
                ram_din  = req1_din;
                last_d   = 1'b1;
                rsp1_d   = ~req1_we;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_INIT;
            cnt_q   <= '0;
            last_q  <= 1'b1;
            rsp0_q  <= 1'b0;
            rsp1_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
            rsp0_q  <= rsp0_d;
            rsp1_q  <= rsp1_d;
        end
    end

    assign init_busy  = (state_q == S_INIT);
    assign req0_ready = gnt0;
    assign req1_ready = gnt1;
    assign rsp0_valid = rsp0_q;
    assign rsp1_valid = rsp1_q;
    assign rsp_data   = ram_dout;

endmodule
